// File: rtl/fsm_pkg.sv
// rtl/fsm_pkg.sv - shared constants for the flow-control FSM and FIFO status block
// Contents: FIFO index constants (bit position on every 5-bit status port)
//           and the field boundaries of the packed umbrales_I threshold bundle.
package fsm_pkg;

  localparam int NUM_FIFO = 5;

  localparam int IDX_MF  = 4;
  localparam int IDX_VC0 = 3;
  localparam int IDX_VC1 = 2;
  localparam int IDX_D0  = 1;
  localparam int IDX_D1  = 0;

  localparam int UMB_W       = 14;
  localparam int UMB_MF_MSB  = 13;
  localparam int UMB_MF_LSB  = 12;
  localparam int UMB_VC0_MSB = 11;
  localparam int UMB_VC0_LSB = 8;
  localparam int UMB_VC1_MSB = 7;
  localparam int UMB_VC1_LSB = 4;
  localparam int UMB_D0_MSB  = 3;
  localparam int UMB_D0_LSB  = 2;
  localparam int UMB_D1_MSB  = 1;
  localparam int UMB_D1_LSB  = 0;

endpackage

// File: rtl/fifo_occ_cnt.sv
// rtl/fifo_occ_cnt.sv - occupancy counter, sticky error and level flags for one FIFO
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   thr [THR_W]         latched threshold for this FIFO
//   push, pop           write / read strobes
//   error_clr           synchronous clear of the sticky error bit
//   empty               count == 0
//   error               sticky overflow / underflow
//   almost_empty        count <= thr
//   almost_full         count + thr >= DEPTH
module fifo_occ_cnt #(
  parameter int DEPTH = 4,
  parameter int THR_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [THR_W-1:0] thr,
  input  logic             push,
  input  logic             pop,
  input  logic             error_clr,
  output logic             empty,
  output logic             error,
  output logic             almost_empty,
  output logic             almost_full
);

  localparam int CW = $clog2(DEPTH + 1);
  // Flag math is one bit wider than the widest operand so count + thr never wraps.
  localparam int FW = ((CW > THR_W) ? CW : THR_W) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [FW-1:0] DEPTH_F = FW'(DEPTH);

  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic          err_now;
  logic          err_q;
  logic [FW-1:0] count_f;
  logic [FW-1:0] thr_f;

  always_comb begin
    count_nxt = count;
    err_now   = 1'b0;
    case ({push, pop})
      2'b10: begin
        if (count < DEPTH_C) count_nxt = count + CW'(1);
        else                 err_now   = 1'b1;
      end
      2'b01: begin
        if (count != '0) count_nxt = count - CW'(1);
        else             err_now   = 1'b1;
      end
      2'b11: begin
        // Simultaneous push/pop is a no-op unless empty: then the push lands
        // and the pop is an underflow.
        if (count == '0) begin
          count_nxt = CW'(1);
          err_now   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
      err_q <= 1'b0;
    end else begin
      count <= count_nxt;
      // A new error outranks a clear in the same cycle.
      if (err_now)        err_q <= 1'b1;
      else if (error_clr) err_q <= 1'b0;
    end
  end

  assign count_f      = FW'(count);
  assign thr_f        = FW'(thr);
  assign empty        = (count == '0);
  assign error        = err_q;
  assign almost_empty = (count_f <= thr_f);
  assign almost_full  = ((count_f + thr_f) >= DEPTH_F);

endmodule

// File: rtl/fifo_status_ctrl.sv
// rtl/fifo_status_ctrl.sv - FIFO occupancy/status tracker for the five datapath FIFOs
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   umbrales_I [14]       packed thresholds MF/VC0/VC1/D0/D1
//   active, idle          FSM state; thresholds load when idle and not active
//   push, pop [5]         per-FIFO strobes (4 MF, 3 VC0, 2 VC1, 1 D0, 0 D1)
//   error_clr             clears the sticky error bits
//   FIFO_empty [5]        count == 0
//   FIFO_error [5]        sticky overflow / underflow
//   almost_empty [5]      count <= threshold
//   almost_full [5]       count + threshold >= depth
module fifo_status_ctrl
  import fsm_pkg::*;
#(
  parameter int MF_DEPTH = 4,
  parameter int VC_DEPTH = 16,
  parameter int D_DEPTH  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [UMB_W-1:0]    umbrales_I,
  input  logic                active,
  input  logic                idle,
  input  logic [NUM_FIFO-1:0] push,
  input  logic [NUM_FIFO-1:0] pop,
  input  logic                error_clr,
  output logic [NUM_FIFO-1:0] FIFO_empty,
  output logic [NUM_FIFO-1:0] FIFO_error,
  output logic [NUM_FIFO-1:0] almost_empty,
  output logic [NUM_FIFO-1:0] almost_full
);

  logic [UMB_W-1:0] thr_q;

  // Shadow copy of the thresholds; active has priority so a running datapath
  // never sees its thresholds move.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)               thr_q <= '0;
    else if (idle && !active) thr_q <= umbrales_I;
  end

  fifo_occ_cnt #(.DEPTH(MF_DEPTH), .THR_W(UMB_MF_MSB - UMB_MF_LSB + 1)) u_mf (
    .clk(clk), .reset(reset), .thr(thr_q[UMB_MF_MSB:UMB_MF_LSB]),
    .push(push[IDX_MF]), .pop(pop[IDX_MF]), .error_clr(error_clr),
    .empty(FIFO_empty[IDX_MF]), .error(FIFO_error[IDX_MF]),
    .almost_empty(almost_empty[IDX_MF]), .almost_full(almost_full[IDX_MF])
  );

  fifo_occ_cnt #(.DEPTH(VC_DEPTH), .THR_W(UMB_VC0_MSB - UMB_VC0_LSB + 1)) u_vc0 (
    .clk(clk), .reset(reset), .thr(thr_q[UMB_VC0_MSB:UMB_VC0_LSB]),
    .push(push[IDX_VC0]), .pop(pop[IDX_VC0]), .error_clr(error_clr),
    .empty(FIFO_empty[IDX_VC0]), .error(FIFO_error[IDX_VC0]),
    .almost_empty(almost_empty[IDX_VC0]), .almost_full(almost_full[IDX_VC0])
  );

  fifo_occ_cnt #(.DEPTH(VC_DEPTH), .THR_W(UMB_VC1_MSB - UMB_VC1_LSB + 1)) u_vc1 (
    .clk(clk), .reset(reset), .thr(thr_q[UMB_VC1_MSB:UMB_VC1_LSB]),
    .push(push[IDX_VC1]), .pop(pop[IDX_VC1]), .error_clr(error_clr),
    .empty(FIFO_empty[IDX_VC1]), .error(FIFO_error[IDX_VC1]),
    .almost_empty(almost_empty[IDX_VC1]), .almost_full(almost_full[IDX_VC1])
  );

  fifo_occ_cnt #(.DEPTH(D_DEPTH), .THR_W(UMB_D0_MSB - UMB_D0_LSB + 1)) u_d0 (
    .clk(clk), .reset(reset), .thr(thr_q[UMB_D0_MSB:UMB_D0_LSB]),
    .push(push[IDX_D0]), .pop(pop[IDX_D0]), .error_clr(error_clr),
    .empty(FIFO_empty[IDX_D0]), .error(FIFO_error[IDX_D0]),
    .almost_empty(almost_empty[IDX_D0]), .almost_full(almost_full[IDX_D0])
  );

  fifo_occ_cnt #(.DEPTH(D_DEPTH), .THR_W(UMB_D1_MSB - UMB_D1_LSB + 1)) u_d1 (
    .clk(clk), .reset(reset), .thr(thr_q[UMB_D1_MSB:UMB_D1_LSB]),
    .push(push[IDX_D1]), .pop(pop[IDX_D1]), .error_clr(error_clr),
    .empty(FIFO_empty[IDX_D1]), .error(FIFO_error[IDX_D1]),
    .almost_empty(almost_empty[IDX_D1]), .almost_full(almost_full[IDX_D1])
  );

endmodule

// File: doc/fifo_status_ctrl.md
# fifo_status_ctrl

FIFO-side counterpart of the flow-control FSM: it consumes the packed threshold bundle `umbrales_I` and the `active`/`idle` status, tracks the occupancy of the five datapath FIFOs (MF, VC0, VC1, D0, D1), and returns the per-FIFO `FIFO_empty` and `FIFO_error` vectors the FSM samples. It also generates almost-full/almost-empty flags against the latched thresholds. It sits between the FSM and the FIFO array, one instance per datapath.

## Interface
- `MF_DEPTH`, 4, main FIFO depth (entries).
- `VC_DEPTH`, 16, depth of VC0 and VC1.
- `D_DEPTH`, 4, depth of D0 and D1.
- `clk`  in  1  single clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-low; 0 clears all state immediately.
- `umbrales_I`  in  14  packed thresholds: [13:12] MF, [11:8] VC0, [7:4] VC1, [3:2] D0, [1:0] D1.
- `active`  in  1  FSM in ACTIVE state; thresholds frozen.
- `idle`  in  1  FSM in IDLE state; thresholds captured.
- `push`  in  5  per-FIFO write strobe; bit 4 MF, 3 VC0, 2 VC1, 1 D0, 0 D1 (same mapping on all 5-bit ports).
- `pop`  in  5  per-FIFO read strobe.
- `error_clr`  in  1  synchronous clear of the sticky error bits.
- `FIFO_empty`  out  5  count == 0.
- `FIFO_error`  out  5  sticky overflow/underflow per FIFO.
- `almost_empty`  out  5  count <= threshold.
- `almost_full`  out  5  count + threshold >= depth.

## Operation
- Threshold shadow registers (2/4/4/2/2 bits) load `umbrales_I` on every rising edge with `idle`=1 and `active`=0; otherwise they hold. `active`=1 always freezes them, even if `idle`=1.
- Each FIFO has an occupancy counter of width $clog2(DEPTH+1); range 0..DEPTH, never wraps.
- Per-FIFO update, evaluated independently each cycle:
  - push only: if count < DEPTH, count+1; else count held, error bit set (overflow).
  - pop only: if count > 0, count-1; else count held at 0, error bit set (underflow).
  - push and pop, 0 < count <= DEPTH: count unchanged, no error (full case legal, slot freed same cycle).
  - push and pop, count == 0: push accepted, pop is underflow; count becomes 1, error bit set.
  - neither: hold.
- `FIFO_error` bits are sticky. Clear only via `reset` or `error_clr`. If `error_clr` and a new error occur in the same cycle, the new error wins (bit stays 1).
- Flag arithmetic is done one bit wider than the counter, so no wrap occurs. A threshold >= depth is legal: `almost_full` is then constant 1 and `almost_empty` is 1 at every count <= threshold.
- Reset values: all counters 0, thresholds 0, `FIFO_error` 0.
  - Flags out of reset: `FIFO_empty` 5'b11111, `almost_empty` 5'b11111 (0 <= 0), `almost_full` 5'b00000.

## Timing
- Counters, thresholds and errors are registered. Flags are combinational from registered counters and thresholds only; there is no input-to-output path.
- Latency: a push/pop in cycle N is reflected in the counter and flags after edge N+1. An error shows in `FIFO_error` after the same edge.
- A threshold change captured at edge N affects the flags from edge N onward.
- Reset asserted mid-operation clears everything asynchronously. The first push is counted on the first rising edge with `reset`=1.

## Structure
- Shared package `fsm_pkg`:
  - FIFO index constants IDX_MF=4, IDX_VC0=3, IDX_VC1=2, IDX_D0=1, IDX_D1=0.
  - `umbrales_I` field MSB/LSB constants, also used by the FSM.
- One sub-module, `fifo_occ_cnt` (parameters DEPTH, THR_W): counter, error bit and the three flags for one FIFO. It is instantiated five times.
- The top level holds the threshold shadow registers and the bit routing.

## Test plan
- Reset and idle load: reset low then high; `idle`=1, `umbrales_I`=14'b01_0001_0001_01_01, one edge -> `FIFO_empty`=5'b11111, `almost_empty`=5'b11111, `almost_full`=0, `FIFO_error`=0.
- VC1 fill with threshold 12 latched, `active`=1: 4 pushes -> `almost_full`[2]=1 (4+12>=16); 16 pushes -> count 16; 17th push -> `FIFO_error`=5'b00100, count stays 16.
- Underflow: pop D1 while empty -> `FIFO_error`[0]=1, `FIFO_empty`[0] stays 1. Push and pop D1 together while empty -> count 1, error stays set. `error_clr` -> `FIFO_error`=0.
- Full push+pop: fill MF to 4, then push and pop MF together -> count stays 4, no error.
- Freeze and mid-run reset: with `active`=1 change `umbrales_I` -> flags unchanged; then drop `reset` for 3 cycles -> all counts 0, thresholds 0, `FIFO_error`=0 immediately.
